// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider family: default width, state
// encoding and the popcount-majority operand approximation.
package div_pkg;

  localparam int DIV_N_DEFAULT = 18;
  localparam int APPROX_MAX_W  = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Majority of the m low bits: the value that replaces bit m-1 when those
  // m bits are collapsed into a single rounded bit.
  function automatic logic majority_bit(input logic [APPROX_MAX_W-1:0] value, input int m);
    int s;
    s = 0;
    for (int i = 0; i < APPROX_MAX_W; i++) begin
      if (i < m && value[i]) s++;
    end
    return (s > m / 2);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/response bundle for seq_restoring_divider: operands plus start in,
// busy/done handshake, results and error flags out.
interface seq_restoring_divider_if #(
  parameter int N = div_pkg::DIV_N_DEFAULT
);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_restoring_divider_divisor_approx.sv
// Effective divisor: the APPROX_M low bits collapse into one majority-rounded
// bit at position APPROX_M-1; APPROX_M=0 passes the divisor through.
module divisor_approx
  import div_pkg::*;
#(
  parameter int N        = DIV_N_DEFAULT,
  parameter int APPROX_M = 0
) (
  input  logic [N-1:0] divisor,
  output logic [N-1:0] d
);

  generate
    if (APPROX_M == 0) begin : g_exact
      assign d = divisor;
    end else begin : g_approx
      logic maj;
      assign maj = majority_bit(APPROX_MAX_W'(divisor), APPROX_M);
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
        if (gi < APPROX_M - 1) begin : g_zero
          assign d[gi] = 1'b0;
        end else if (gi == APPROX_M - 1) begin : g_round
          assign d[gi] = maj;
        end else begin : g_keep
          assign d[gi] = divisor[gi];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit
// per cycle, start/busy/done handshake, registered results and error flags.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N        = DIV_N_DEFAULT,
  parameter int APPROX_M = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0] d_eff;

  divisor_approx #(
    .N        (N),
    .APPROX_M (APPROX_M)
  ) u_divisor_approx (
    .divisor (bus.divisor),
    .d       (d_eff)
  );

  state_t         state_reg;
  logic [N-1:0]   r_reg;      // partial remainder; always < D so N bits suffice
  logic [N-1:0]   lo_reg;     // dividend bits shift out, quotient bits shift in
  logic [N-1:0]   d_reg;
  logic [CW-1:0]  count_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [N-1:0]   quotient_reg;
  logic [N-1:0]   remainder_reg;
  logic           dbz_reg;
  logic           ovf_reg;

  logic [N:0]     shifted;
  logic [N:0]     trial;
  logic           fits;
  logic [N-1:0]   r_next;
  logic [N-1:0]   lo_next;

  // Borrow out of the N+1-bit trial subtraction is the sign of T.
  always_comb begin
    shifted = {r_reg, lo_reg[N-1]};
    trial   = shifted - {1'b0, d_reg};
    fits    = ~trial[N];
    r_next  = fits ? trial[N-1:0] : shifted[N-1:0];
    lo_next = {lo_reg[N-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      lo_reg        <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            d_reg   <= d_eff;
            dbz_reg <= 1'b0;
            ovf_reg <= 1'b0;
            if (d_eff == '0 || bus.dividend[2*N-1:N] >= d_eff) begin
              // Quotient would not fit in N bits: saturate and finish at once.
              state_reg     <= DONE;
              done_reg      <= 1'b1;
              dbz_reg       <= (d_eff == '0);
              ovf_reg       <= (d_eff != '0);
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend[N-1:0];
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
              r_reg     <= bus.dividend[2*N-1:N];
              lo_reg    <= bus.dividend[N-1:0];
              count_reg <= CW'(N);
            end
          end
        end
        RUN: begin
          r_reg     <= r_next;
          lo_reg    <= lo_next;
          count_reg <= count_reg - 1'b1;
          if (count_reg == CW'(1)) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            quotient_reg  <= lo_next;
            remainder_reg <= r_next;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Drives an exact (M=0) and an approximate (M=8) divider with identical
// operands and checks both against an arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int N  = 18;
  localparam int M8 = 8;
  localparam longint NMASK = (64'd1 << N) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.N(N)) bus0 ();
  seq_restoring_divider_if #(.N(N)) bus8 ();

  seq_restoring_divider #(.N(N), .APPROX_M(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seq_restoring_divider #(.N(N), .APPROX_M(M8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Effective divisor from plain arithmetic: clear the m low bits, then set
  // bit m-1 when more than half of them were ones.
  function automatic longint eff_d(input longint dvs, input int m);
    longint d;
    int s;
    if (m == 0) return dvs;
    s = 0;
    for (int i = 0; i < m; i++) s += int'((dvs >> i) & 1);
    d = (dvs >> m) << m;
    if (s > m / 2) d = d | (64'd1 << (m - 1));
    return d;
  endfunction

  task automatic model(input longint dvd, input longint dvs, input int m,
                       output longint q, output longint r, output longint d,
                       output bit dz, output bit ov, output int lat);
    d  = eff_d(dvs, m);
    dz = (d == 0);
    ov = !dz && ((dvd >> N) >= d);
    if (dz || ov) begin
      q   = NMASK;
      r   = dvd & NMASK;
      lat = 1;
    end else begin
      q   = dvd / d;
      r   = dvd % d;
      lat = N + 1;
    end
  endtask

  task automatic set_operands(input longint dvd, input longint dvs);
    bus0.dividend = dvd[2*N-1:0];
    bus0.divisor  = dvs[N-1:0];
    bus8.dividend = dvd[2*N-1:0];
    bus8.divisor  = dvs[N-1:0];
  endtask

  task automatic run_op(input longint dvd, input longint dvs, input bit mid_start);
    int     lat[2]   = '{0, 0};
    int     dcnt[2]  = '{0, 0};
    int     bcnt[2]  = '{0, 0};
    longint qs[2]    = '{0, 0};
    longint rs[2]    = '{0, 0};
    bit     zs[2]    = '{0, 0};
    bit     os[2]    = '{0, 0};
    longint eq, er, ed;
    bit     ez, eo;
    int     el, m;

    @(negedge clk);
    set_operands(dvd, dvs);
    bus0.start = 1'b1;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus8.start = 1'b0;
    // Operands may wander freely once accepted.
    set_operands({$urandom, $urandom}, longint'($urandom));

    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus0.done) begin
        dcnt[0]++;
        if (lat[0] == 0) begin
          lat[0] = cyc; qs[0] = bus0.quotient; rs[0] = bus0.remainder;
          zs[0] = bus0.div_by_zero; os[0] = bus0.overflow;
        end
      end
      if (bus8.done) begin
        dcnt[1]++;
        if (lat[1] == 0) begin
          lat[1] = cyc; qs[1] = bus8.quotient; rs[1] = bus8.remainder;
          zs[1] = bus8.div_by_zero; os[1] = bus8.overflow;
        end
      end
      if (bus0.busy) bcnt[0]++;
      if (bus8.busy) bcnt[1]++;
      if (mid_start && cyc == 5) begin
        set_operands(64'd3, 64'd1);
        bus0.start = 1'b1;
        bus8.start = 1'b1;
      end else begin
        bus0.start = 1'b0;
        bus8.start = 1'b0;
      end
      if (lat[0] != 0 && lat[1] != 0 && cyc > lat[0] && cyc > lat[1]) break;
    end
    bus0.start = 1'b0;
    bus8.start = 1'b0;

    for (int k = 0; k < 2; k++) begin
      m = (k == 0) ? 0 : M8;
      model(dvd, dvs, m, eq, er, ed, ez, eo, el);
      check_val($sformatf("latency_m%0d", m), lat[k], el);
      check_val($sformatf("quotient_m%0d", m), qs[k], eq);
      check_val($sformatf("remainder_m%0d", m), rs[k], er);
      check_val($sformatf("div_by_zero_m%0d", m), zs[k], ez);
      check_val($sformatf("overflow_m%0d", m), os[k], eo);
      check_val($sformatf("done_pulses_m%0d", m), dcnt[k], 1);
      check_val($sformatf("busy_cycles_m%0d", m), bcnt[k], el - 1);
      if (!ez && !eo) begin
        check_val($sformatf("invariant_m%0d", m), qs[k] * ed + rs[k], dvd);
        check_val($sformatf("rem_lt_d_m%0d", m), longint'(rs[k] < ed), 1);
      end
      if (k == 0) check_val("quotient_hold_m0", bus0.quotient, eq);
    end
    $display("op dividend=0x%0h divisor=0x%0h | m0 q=0x%0h r=0x%0h z=%0d o=%0d lat=%0d | m8 q=0x%0h r=0x%0h z=%0d o=%0d lat=%0d",
             dvd, dvs, qs[0], rs[0], zs[0], os[0], lat[0], qs[1], rs[1], zs[1], os[1], lat[1]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, bus0.busy, 0);
    check_val({tag, "_done"}, bus0.done, 0);
    check_val({tag, "_quotient"}, bus0.quotient, 0);
    check_val({tag, "_remainder"}, bus0.remainder, 0);
    check_val({tag, "_div_by_zero"}, bus0.div_by_zero, 0);
    check_val({tag, "_overflow"}, bus0.overflow, 0);
    check_val({tag, "_quotient_m8"}, bus8.quotient, 0);
    check_val({tag, "_div_by_zero_m8"}, bus8.div_by_zero, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint dvs, hi, lo;
    int done_seen;

    rst = 1'b1;
    bus0.start = 1'b0;
    bus8.start = 1'b0;
    set_operands(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run_op(64'd1000, 64'd7, 1'b0);
    run_op(64'hFFFFC0001, 64'h3FFFF, 1'b0);
    run_op(64'hFFFF80001, 64'h3FFFF, 1'b0);
    run_op(64'h140000, 64'd5, 1'b0);
    run_op(64'h140000, 64'd0, 1'b0);
    run_op(64'd1280, 64'h000FF, 1'b0);
    run_op(64'd1280, 64'h0000F, 1'b0);
    run_op(64'd0, 64'd1, 1'b0);
    run_op(((64'h3FFFF - 1) << N) | 64'h3FFFF, 64'h3FFFF, 1'b0);
    run_op(64'h50000, 64'h1234, 1'b1);

    // Reset in the middle of a running division.
    @(negedge clk);
    set_operands(64'h50000, 64'h1234);
    bus0.start = 1'b1;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus0.done || bus8.done) done_seen++;
    end
    check_val("midrun_reset_no_done", done_seen, 0);
    run_op(64'd1000, 64'd7, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      dvs = longint'($urandom) & NMASK;
      if ($urandom_range(31, 0) == 0) dvs = 0;
      if (dvs != 0 && $urandom_range(7, 0) != 0)
        hi = longint'($urandom_range(int'(dvs - 1), 0));
      else
        hi = longint'($urandom) & NMASK;
      lo = longint'($urandom) & NMASK;
      run_op((hi << N) | lo, dvs, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
